// File: rtl/dc_seq_ctrl_if.sv
// Configuration channel for dc_seq_ctrl: start/step/skip offered under a
// valid/ready handshake from the control-register block.
interface dc_seq_ctrl_if #(
    parameter int WIDTH = 7
);
    // Handshake: a transfer happens on every rising clock edge where
    // cfg_valid and cfg_ready are both high. The master holds cfg_valid and
    // the three fields stable until that edge. cfg_ready never depends on
    // cfg_valid.
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_step;
    logic [WIDTH-1:0] cfg_skip;

    modport master (
        output cfg_valid,
        output cfg_start,
        output cfg_step,
        output cfg_skip,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_start,
        input  cfg_step,
        input  cfg_skip,
        output cfg_ready
    );
endinterface

// File: rtl/dc_seq_ctrl.sv
// Sequencing controller for the skip down-counter: IDLE/RUN/PAUSE/DONE.
// Define DC_SEQ_WRAP_EN to reload start on underflow instead of stopping.
module dc_seq_ctrl #(
    parameter int WIDTH     = 7,
    parameter int DEF_START = 127,
    parameter int DEF_STEP  = 2,
    parameter int DEF_SKIP  = 7
) (
    input  logic             clock,
    input  logic             reset,
    dc_seq_ctrl_if.slave     cfg_bus,
    input  logic             go,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             skip_hit,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] skip_r;
    logic [WIDTH-1:0] count_nx;
    logic             skip_hit_nx;

`ifdef DC_SEQ_WRAP_EN
    logic             wrap_pulse;
    logic             wrap_nx;
`endif

    // Datapath: one or two subtractions, borrow from the extra top bit.
    logic [WIDTH:0]   diff1;
    logic [WIDTH:0]   diff2;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             b1;
    logic             b2;
    logic             skip_case;
    logic             underflow;
    logic [WIDTH-1:0] next_val;

    assign diff1     = {1'b0, count} - {1'b0, step_r};
    assign d1        = diff1[WIDTH-1:0];
    assign b1        = diff1[WIDTH];
    assign diff2     = {1'b0, d1} - {1'b0, step_r};
    assign d2        = diff2[WIDTH-1:0];
    assign b2        = diff2[WIDTH];
    assign skip_case = !b1 && (d1 == skip_r);
    assign underflow = b1 || (skip_case && b2);
    assign next_val  = skip_case ? d2 : d1;

    logic cfg_fire;
    logic ready_int;

    assign ready_int = (state == S_IDLE) || (state == S_DONE);
    assign cfg_fire  = cfg_bus.cfg_valid && ready_int;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic; abort outranks pause, go and underflow
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cfg_fire) begin
                    state_nx = S_IDLE;
                end else if (go) begin
                    state_nx = S_RUN;
                end
            end
            S_DONE: begin
                if (cfg_fire || abort) begin
                    state_nx = S_IDLE;
                end else if (go) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (pause) begin
                    state_nx = S_PAUSE;
                end else if (underflow) begin
`ifdef DC_SEQ_WRAP_EN
                    state_nx = S_RUN;
`else
                    state_nx = S_DONE;
`endif
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (!pause) begin
                    state_nx = S_RUN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy              = (state == S_RUN) || (state == S_PAUSE);
        cfg_bus.cfg_ready = ready_int;
        fsm_state         = state;
`ifdef DC_SEQ_WRAP_EN
        done              = wrap_pulse;
`else
        done              = (state == S_DONE);
`endif
    end

    // Count update; a handshake beats go in the same cycle
    always_comb begin
        count_nx    = count;
        skip_hit_nx = 1'b0;
`ifdef DC_SEQ_WRAP_EN
        wrap_nx     = 1'b0;
`endif
        if (cfg_fire) begin
            count_nx = cfg_bus.cfg_start;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        count_nx = start_r;
                    end
                end
                S_DONE: begin
                    if (abort || go) begin
                        count_nx = start_r;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        count_nx = start_r;
                    end else if (!pause) begin
                        if (underflow) begin
`ifdef DC_SEQ_WRAP_EN
                            count_nx = start_r;
                            wrap_nx  = 1'b1;
`else
                            count_nx = count;
`endif
                        end else begin
                            count_nx    = next_val;
                            skip_hit_nx = skip_case;
                        end
                    end
                end
                S_PAUSE: begin
                    if (abort) begin
                        count_nx = start_r;
                    end
                end
                default: count_nx = count;
            endcase
        end
    end

    // Configuration and count registers; a zero step is stored as one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_r  <= WIDTH'(DEF_START);
            step_r   <= WIDTH'(DEF_STEP);
            skip_r   <= WIDTH'(DEF_SKIP);
            count    <= WIDTH'(DEF_START);
            skip_hit <= 1'b0;
        end else begin
            if (cfg_fire) begin
                start_r <= cfg_bus.cfg_start;
                step_r  <= (cfg_bus.cfg_step == '0) ? WIDTH'(1) : cfg_bus.cfg_step;
                skip_r  <= cfg_bus.cfg_skip;
            end
            count    <= count_nx;
            skip_hit <= skip_hit_nx;
        end
    end

`ifdef DC_SEQ_WRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= wrap_nx;
        end
    end
`endif

endmodule

// File: tb/tb_dc_seq_ctrl.sv
// Self-checking bench for dc_seq_ctrl: scenario tasks with a scoreboard of
// expected {skip_hit, count} pairs. Honors DC_SEQ_WRAP_EN when defined.
module tb_dc_seq_ctrl;

    localparam int W = 7;

    logic         clock;
    logic         reset;
    logic         go;
    logic         pause;
    logic         abort;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         skip_hit;
    logic [1:0]   fsm_state;

    int tests_run;
    int tests_failed;

    logic [W:0] exp_q[$];

    dc_seq_ctrl_if #(.WIDTH(W)) cfg_bus ();

    dc_seq_ctrl #(
        .WIDTH(W), .DEF_START(127), .DEF_STEP(2), .DEF_SKIP(7)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_bus  (cfg_bus),
        .go       (go),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .skip_hit (skip_hit),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // driver tasks
    task automatic cfg_write(input logic [W-1:0] st, input logic [W-1:0] sp,
                             input logic [W-1:0] sk);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_start = st;
        cfg_bus.cfg_step  = sp;
        cfg_bus.cfg_skip  = sk;
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_ready_before_write: got %b required 1", cfg_bus.cfg_ready);
        end
        tick();
        cfg_bus.cfg_valid = 1'b0;
        tests_run++;
        if (count !== st || busy !== 1'b0 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL cfg_write_load: count %0d busy %b state %0d required count %0d busy 0 state 0",
                     count, busy, fsm_state, st);
        end
    endtask

    task automatic wait_count(input logic [W-1:0] target, input string tag);
        int n;
        n = 0;
        while (count !== target && n < 80) begin
            tick();
            n++;
        end
        tests_run++;
        if (count !== target) begin
            tests_failed++;
            $display("FAIL %s: count %0d required %0d (cycle budget expired)", tag, count, target);
        end
    endtask

    // Build the expected trace from start/step/skip, pulse go, then compare.
    task automatic run_seq(input int st, input int sp, input int sk, input string tag);
        int         s;
        int         c;
        int         d1;
        int         d2;
        int         last;
        logic       hit;
        logic [W:0] e;
        s = (sp == 0) ? 1 : sp;
        c = st;
        exp_q.push_back({1'b0, W'(st)});
        for (int i = 0; i < 200; i++) begin
            d1 = c - s;
            if (d1 < 0) break;
            hit = 1'b0;
            if (d1 == sk) begin
                d2 = d1 - s;
                if (d2 < 0) break;
                c   = d2;
                hit = 1'b1;
            end else begin
                c = d1;
            end
            exp_q.push_back({hit, W'(c)});
        end
        last = c;
        go = 1'b1;
        tick();
        go = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if ({skip_hit, count} !== e || busy !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_step: hit %b count %0d busy %b done %b required hit %b count %0d busy 1 done 0",
                         tag, skip_hit, count, busy, done, e[W], e[W-1:0]);
            end
            if (exp_q.size() > 0) tick();
        end
        tick();
`ifdef DC_SEQ_WRAP_EN
        tests_run++;
        if (count !== W'(st) || done !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_wrap: count %0d done %b busy %b required count %0d done 1 busy 1",
                     tag, count, done, busy, st);
        end
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_wrap_pulse: done %b required 0", tag, done);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        tests_run++;
        if (count !== W'(last) || done !== 1'b1 || busy !== 1'b0 || skip_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_end: count %0d done %b busy %b hit %b required count %0d done 1 busy 0 hit 0",
                     tag, count, done, busy, skip_hit, last);
        end
        tick();
        tests_run++;
        if (count !== W'(last) || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_done_hold: count %0d done %b required count %0d done 1",
                     tag, count, done, last);
        end
`endif
    endtask

    task automatic test_reset();
        tests_run++;
        if (count !== 7'd127 || cfg_bus.cfg_ready !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0 || skip_hit !== 1'b0 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: count %0d ready %b busy %b done %b hit %b state %0d required 127 1 0 0 0 0",
                     count, cfg_bus.cfg_ready, busy, done, skip_hit, fsm_state);
        end
    endtask

    task automatic test_default_run();
        run_seq(127, 2, 7, "default");
    endtask

    task automatic test_cfg_run();
        cfg_write(7'd20, 7'd3, 7'd11);
        run_seq(20, 3, 11, "cfg20");
    endtask

    task automatic test_pause();
        logic [W-1:0] e;
        cfg_write(7'd127, 7'd2, 7'd7);
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_count(7'd101, "reach_101");
        pause = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 7'd101});
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (count !== e || busy !== 1'b1 || fsm_state !== 2'd2) begin
                tests_failed++;
                $display("FAIL pause_hold: count %0d busy %b state %0d required count %0d busy 1 state 2",
                         count, busy, fsm_state, e);
            end
        end
        pause = 1'b0;
        exp_q.push_back({1'b0, 7'd101});
        exp_q.push_back({1'b0, 7'd99});
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (count !== e || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL pause_resume: count %0d busy %b required count %0d busy 1", count, busy, e);
            end
        end
        wait_count(7'd45, "reach_45");
        pause = 1'b1;
        tick();
        tests_run++;
        if (count !== 7'd45 || fsm_state !== 2'd2) begin
            tests_failed++;
            $display("FAIL pause_45: count %0d state %0d required 45 2", count, fsm_state);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pause = 1'b0;
        tests_run++;
        if (count !== 7'd127 || busy !== 1'b0 || fsm_state !== 2'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_pause: count %0d busy %b state %0d done %b required 127 0 0 0",
                     count, busy, fsm_state, done);
        end
    endtask

    task automatic test_cfg_during_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_start = 7'd50;
        cfg_bus.cfg_step  = 7'd4;
        cfg_bus.cfg_skip  = 7'd0;
        #1;
        tests_run++;
        if (cfg_bus.cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_in_run: got %b required 0", cfg_bus.cfg_ready);
        end
        exp_q.push_back({1'b0, 7'd125});
        exp_q.push_back({1'b0, 7'd123});
        for (int i = 0; i < 2; i++) begin
            logic [W:0] e;
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if ({skip_hit, count} !== e) begin
                tests_failed++;
                $display("FAIL cfg_ignored_run: count %0d required %0d", count, e[W-1:0]);
            end
        end
        cfg_bus.cfg_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (count !== 7'd127 || cfg_bus.cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_unchanged: count %0d ready %b required 127 1", count, cfg_bus.cfg_ready);
        end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_start = 7'd30;
        cfg_bus.cfg_step  = 7'd4;
        cfg_bus.cfg_skip  = 7'd22;
        go = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        go = 1'b0;
        tests_run++;
        if (count !== 7'd30 || busy !== 1'b0 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL cfg_beats_go: count %0d busy %b state %0d required 30 0 0", count, busy, fsm_state);
        end
        run_seq(30, 4, 22, "cfg30");
    endtask

    task automatic test_reset_mid_run();
        cfg_write(7'd70, 7'd5, 7'd0);
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_count(7'd60, "reach_60");
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (count !== 7'd127 || busy !== 1'b0 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: count %0d busy %b state %0d required 127 0 0", count, busy, fsm_state);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tests_run++;
        if (count !== 7'd125) begin
            tests_failed++;
            $display("FAIL reset_restores_def: count %0d required 125", count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_step_zero();
        cfg_write(7'd10, 7'd0, 7'd5);
        run_seq(10, 0, 5, "step0");
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b1;
        go                = 1'b0;
        pause             = 1'b0;
        abort             = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_start = '0;
        cfg_bus.cfg_step  = '0;
        cfg_bus.cfg_skip  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        test_reset();
        test_default_run();
        test_cfg_run();
        test_pause();
        test_cfg_during_run();
        test_reset_mid_run();
        test_step_zero();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
